mem_port_arbiter: RTL and testbench

Parametrised arbiter that shares the single-port synchronous data memory between NUM_CH requesters: the core load/store path, the LCD memory reader, and future debug/DMA ports. It supersedes the 2:1 select-driven address mux on the data memory address input. Arbitration is fixed-priority or round-robin, with an optional per-channel lock for multi-word bursts. Read data is returned to the granting channel after a fixed, parametrised memory latency.

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous data memory between NUM_CH requesters.
// Fixed-priority or round-robin arbitration, optional burst lock, read data routed back after MEM_LATENCY.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 1,
  parameter int RR_MODE     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH-1:0]            ch_lock,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         mem_wren,
  output logic                         mem_rden,
  input  logic [DATA_WIDTH-1:0]        mem_q
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0]       r_rr_ptr;
  logic [PTR_W-1:0]       r_lock_ch;
  logic                   r_lock_valid;
  logic [MEM_LATENCY-1:0] r_pv;
  logic [PTR_W-1:0]       r_pid [MEM_LATENCY];

  logic              w_lock_hold;
  logic              w_found;
  logic              w_we;
  logic [PTR_W-1:0]  w_win;
  logic [NUM_CH-1:0] w_gnt;

  // k-th candidate in the search order: rotated from base in RR mode, plain index otherwise.
  function automatic logic [PTR_W-1:0] cand(input logic [PTR_W-1:0] base, input int unsigned off);
    int unsigned s;
    s = ((RR_MODE != 0) ? 32'(base) : 32'd0) + off;
    if (s >= unsigned'(NUM_CH)) s = s - unsigned'(NUM_CH);
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    int unsigned s;
    s = 32'(p) + 32'd1;
    if (s >= unsigned'(NUM_CH)) s = 32'd0;
    return s[PTR_W-1:0];
  endfunction

  assign w_lock_hold = r_lock_valid & ch_req[r_lock_ch] & ch_lock[r_lock_ch];

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    if (w_lock_hold) begin
      w_found = 1'b1;
      w_win   = r_lock_ch;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (!w_found && ch_req[cand(r_rr_ptr, k)]) begin
          w_found = 1'b1;
          w_win   = cand(r_rr_ptr, k);
        end
      end
    end
  end

  always_comb begin
    w_gnt     = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    w_we      = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_found && (w_win == i[PTR_W-1:0])) begin
        w_gnt[i]  = 1'b1;
        mem_addr  = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata = ch_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_we      = ch_we[i];
      end
    end
  end

  assign ch_gnt   = w_gnt;
  assign mem_wren = w_found & w_we;
  assign mem_rden = w_found & ~w_we;

  // A held lock keeps the pointer frozen so the burst does not cost other channels their turn.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_ch    <= '0;
    end else if (w_found) begin
      if (!w_lock_hold) r_rr_ptr <= inc_ptr(w_win);
      r_lock_valid <= ch_lock[w_win];
      r_lock_ch    <= w_win;
    end else begin
      r_lock_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int unsigned i = 0; i < MEM_LATENCY; i++) r_pid[i] <= '0;
    end else begin
      r_pv[0]  <= mem_rden;
      r_pid[0] <= w_win;
      for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_pid[i] <= r_pid[i-1];
      end
    end
  end

  always_comb begin
    ch_rvalid = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_pv[MEM_LATENCY-1] && (r_pid[MEM_LATENCY-1] == i[PTR_W-1:0])) ch_rvalid[i] = 1'b1;
    end
  end

  assign ch_rdata = mem_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: 3-channel RR instance with latency 2 plus a 2-channel fixed-priority instance.
module tb_mem_port_arbiter;
  localparam int AW  = 18;
  localparam int DW  = 32;
  localparam int NC  = 3;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Main instance stimulus
  logic [NC-1:0]    req, we, lk;
  logic [AW-1:0]    addr [NC];
  logic [DW-1:0]    wd   [NC];
  logic [NC*AW-1:0] ch_addr;
  logic [NC*DW-1:0] ch_wdata;
  logic [NC-1:0]    ch_gnt, ch_rvalid;
  logic [DW-1:0]    ch_rdata, mem_wdata, mem_q;
  logic [AW-1:0]    mem_addr;
  logic             mem_wren, mem_rden;

  always_comb begin
    ch_addr  = '0;
    ch_wdata = '0;
    for (int i = 0; i < NC; i++) begin
      ch_addr[i*AW +: AW]  = addr[i];
      ch_wdata[i*DW +: DW] = wd[i];
    end
  end

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .MEM_LATENCY(LAT), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .ch_req(req), .ch_we(we), .ch_lock(lk), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_gnt(ch_gnt), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q));

  // Fixed-priority instance
  logic [1:0]    f_req, f_we, f_lock, f_gnt, f_rvalid;
  logic [2*AW-1:0] f_addr;
  logic [2*DW-1:0] f_wdata;
  logic [DW-1:0] f_rdata, f_mwdata;
  logic [AW-1:0] f_maddr;
  logic          f_mwren, f_mrden;
  logic [DW-1:0] f_q;
  assign f_q = 32'h5A5A_0F0F;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(2), .MEM_LATENCY(1), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .ch_req(f_req), .ch_we(f_we), .ch_lock(f_lock), .ch_addr(f_addr), .ch_wdata(f_wdata),
    .ch_gnt(f_gnt), .ch_rvalid(f_rvalid), .ch_rdata(f_rdata), .mem_addr(f_maddr), .mem_wdata(f_mwdata),
    .mem_wren(f_mwren), .mem_rden(f_mrden), .mem_q(f_q));

  // Environment memory: synchronous, LAT cycles from address to q
  bit   [DW-1:0] envmem [0:(1<<AW)-1];
  logic [DW-1:0] q_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    if (mem_wren) envmem[mem_addr] <= mem_wdata;
    q_pipe[0] <= envmem[mem_addr];
    for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: priority order + lock owner, reference memory, scoreboard of expected reads
  typedef struct {int ch; logic [DW-1:0] data; int due;} rd_t;
  rd_t           sbq [$];
  bit   [DW-1:0] refmem [0:(1<<AW)-1];
  int            m_next = 0;
  int            m_lock = -1;
  int            m_w, m_c;
  bit            m_held;
  logic [NC-1:0] m_eg;
  logic [NC-1:0] gnt_seen = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_next = 0;
        m_lock = -1;
        sbq.delete();
        gnt_seen = '0;
      end else begin
        m_w = -1;
        m_held = 1'b0;
        if (m_lock >= 0 && req[m_lock] && lk[m_lock]) begin
          m_w = m_lock;
          m_held = 1'b1;
        end else begin
          for (int k = 0; k < NC; k++) begin
            m_c = (m_next + k) % NC;
            if (m_w < 0 && req[m_c]) m_w = m_c;
          end
        end
        m_eg = '0;
        if (m_w >= 0) m_eg[m_w] = 1'b1;
        chk("gnt", 64'(ch_gnt), 64'(m_eg));
        if (m_w >= 0)
          chk("mem_bus", {mem_wren, mem_rden, mem_addr, mem_wdata}, {we[m_w], ~we[m_w], addr[m_w], wd[m_w]});
        else
          chk("mem_idle", {mem_wren, mem_rden, mem_addr, mem_wdata}, 64'd0);
        gnt_seen = ch_gnt;
        if (m_w >= 0) begin
          if (we[m_w]) refmem[addr[m_w]] = wd[m_w];
          else sbq.push_back('{m_w, refmem[addr[m_w]], cyc + LAT});
          if (!m_held) m_next = (m_w + 1) % NC;
          m_lock = lk[m_w] ? m_w : -1;
        end else begin
          m_lock = -1;
        end
      end
    end
  end

  // Monitor: read returns against scoreboard
  rd_t           mon_e;
  logic [NC-1:0] mon_oh;
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.ch] = 1'b1;
        chk("rvalid", 64'(ch_rvalid), 64'(mon_oh));
        chk("rdata", 64'(ch_rdata), 64'(mon_e.data));
      end else begin
        chk("rvalid_idle", 64'(ch_rvalid), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setch(input int c, input bit r, input bit w, input bit l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c] = r; we[c] = w; lk[c] = l; addr[c] = a; wd[c] = d;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NC; c++) setch(c, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    idle_all();
    f_req = '0; f_we = '0; f_lock = '0; f_wdata = '0;
    f_addr = {18'd6, 18'd5};

    // Reset state
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", 64'(ch_gnt), 64'd0);
      chk("rst_rvalid", 64'(ch_rvalid), 64'd0);
      chk("rst_mem", {mem_wren, mem_rden, mem_addr}, 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Fixed priority: ch0 always wins, ch1 only once ch0 drops
    f_req = 2'b11;
    repeat (4) begin
      @(negedge clk);
      chk("fix_gnt0", 64'(f_gnt), 64'd1);
      chk("fix_addr0", 64'(f_maddr), 64'd5);
      tick();
    end
    f_req = 2'b10;
    @(negedge clk);
    chk("fix_gnt1", 64'(f_gnt), 64'd2);
    chk("fix_addr1", 64'(f_maddr), 64'd6);
    tick();
    f_req = 2'b00;
    @(negedge clk);
    chk("fix_rvalid", 64'(f_rvalid), 64'd2);
    chk("fix_rdata", 64'(f_rdata), 64'h5A5A_0F0F);
    tick();

    // Round robin, all three requesting
    for (int c = 0; c < NC; c++) setch(c, 1'b1, 1'b0, 1'b0, AW'(32 + c), '0);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      chk("rr_seq", 64'(ch_gnt), 64'(1) << (s % 3));
      tick();
    end
    idle_all();

    // Preload two words through ch0
    setch(0, 1'b1, 1'b1, 1'b0, 18'h10, 32'hAAAA_0001);
    tick();
    setch(0, 1'b1, 1'b1, 1'b0, 18'h11, 32'hAAAA_0002);
    tick();
    idle_all();
    tick();

    // Pipelined reads from two channels
    setch(1, 1'b1, 1'b0, 1'b0, 18'h10, '0);
    @(negedge clk);
    chk("pipe_gnt1", 64'(ch_gnt), 64'd2);
    tick();
    idle_all();
    setch(0, 1'b1, 1'b0, 1'b0, 18'h11, '0);
    @(negedge clk);
    chk("pipe_gnt0", 64'(ch_gnt), 64'd1);
    tick();
    idle_all();
    @(negedge clk);
    chk("pipe_rv1", {ch_rvalid, ch_rdata}, {3'b010, 32'hAAAA_0001});
    tick();
    @(negedge clk);
    chk("pipe_rv0", {ch_rvalid, ch_rdata}, {3'b001, 32'hAAAA_0002});
    tick();

    // Lock burst on ch1 against a competing ch0
    setch(0, 1'b1, 1'b0, 1'b0, 18'h30, '0);
    for (int k = 0; k < 4; k++) begin
      setch(1, 1'b1, 1'b0, 1'b1, AW'(k), '0);
      @(negedge clk);
      chk("lock_gnt", 64'(ch_gnt), 64'd2);
      tick();
    end
    setch(1, 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("lock_release", 64'(ch_gnt), 64'd1);
    tick();

    // Write then read the top address, then reset with a read in flight
    setch(0, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_gnt", {ch_gnt, mem_wren, mem_rden}, {3'b001, 2'b10});
    tick();
    setch(0, 1'b1, 1'b0, 1'b0, 18'h3FFFF, '0);
    tick();
    idle_all();
    tick();
    @(negedge clk);
    chk("wr_rd_back", {ch_rvalid, ch_rdata}, {3'b001, 32'hDEAD_BEEF});
    tick();
    setch(0, 1'b1, 1'b0, 1'b0, 18'h3FFFF, '0);
    @(negedge clk);
    chk("rst_rd_gnt", 64'(ch_gnt), 64'd1);
    tick();
    idle_all();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_drop_rv", 64'(ch_rvalid), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NC; c++) begin
        if (!req[c] || gnt_seen[c]) begin
          if ($urandom_range(0, 9) < 6)
            setch(c, 1'b1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  AW'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 18'h3FFF0 : 18'h0), $urandom);
          else
            setch(c, 1'b0, 1'b0, 1'b0, '0, '0);
        end
      end
      tick();
    end
    idle_all();
    repeat (LAT + 2) tick();
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
